// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module   : uart_tx_sched
// Purpose  : Shares one UART transmitter between two byte-stream channels.
//            Arbitration is round-robin. A frame holds the transmitter until
//            the byte marked last. Drives the tx_start/tx_data/tx_busy
//            handshake of the UART TX core.
// Options  : UART_TX_SCHED_GAP_EN - when defined, each byte is followed by
//            GAP_CYCLES idle cycles before the next grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_sched #(
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 348
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [1:0]       in_valid,
  input  logic [15:0]      in_data,
  input  logic [1:0]       in_last,
  output logic [1:0]       in_ready,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic             owner,
  output logic             locked,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             idle
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_tx_data;
  logic             r_owner;
  logic             r_locked;
  logic [CNT_W-1:0] r_sent_cnt;
  logic [1:0]       w_elig;
  logic             w_grant;
  logic             w_grant_ch;
  logic             w_byte_done;

`ifdef UART_TX_SCHED_GAP_EN
  localparam int c_gap_w = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(GAP_CYCLES - 1);
  localparam bit c_gap_on = (GAP_CYCLES > 0);
  logic [c_gap_w-1:0] r_gap_cnt;
`else
  // GAP_CYCLES has no effect in this build.
  logic w_unused_gap_cfg;
  assign w_unused_gap_cfg = (GAP_CYCLES > 0);
`endif

  // Channels allowed to win: an open frame restricts the grant to its owner.
  always_comb begin
    w_elig = in_valid;
    if (r_locked) begin
      w_elig = r_owner ? {in_valid[1], 1'b0} : {1'b0, in_valid[0]};
    end
  end

  // When both are eligible the channel that did not go last wins.
  assign w_grant_ch  = (&w_elig) ? ~r_owner : w_elig[1];
  assign w_grant     = (r_state == S_IDLE) && !tx_busy && (|w_elig);
  assign w_byte_done = (r_state == S_BUSY) && !tx_busy;

  assign in_ready = w_grant ? (w_grant_ch ? 2'b10 : 2'b01) : 2'b00;
  assign tx_start = (r_state == S_START);
  assign idle     = (r_state == S_IDLE);
  assign tx_data  = r_tx_data;
  assign owner    = r_owner;
  assign locked   = r_locked;
  assign sent_cnt = r_sent_cnt;

  // State register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the grant / start / busy / gap sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (tx_busy) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!tx_busy) begin
`ifdef UART_TX_SCHED_GAP_EN
          w_state_next = c_gap_on ? S_GAP : S_IDLE;
`else
          w_state_next = S_IDLE;
`endif
        end
      end
      S_GAP: begin
`ifdef UART_TX_SCHED_GAP_EN
        if (r_gap_cnt == '0) begin
          w_state_next = S_IDLE;
        end
`else
        w_state_next = S_IDLE;
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture the accepted byte, owner and frame lock; count finished bytes.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_tx_data  <= 8'h00;
      r_owner    <= 1'b1;
      r_locked   <= 1'b0;
      r_sent_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_tx_data <= w_grant_ch ? in_data[15:8] : in_data[7:0];
        r_owner   <= w_grant_ch;
        r_locked  <= ~in_last[w_grant_ch];
      end
      if (w_byte_done) begin
        r_sent_cnt <= r_sent_cnt + CNT_W'(1);
      end
    end
  end

`ifdef UART_TX_SCHED_GAP_EN
  // Inter-byte gap down-counter, loaded as the byte completes.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_gap_cnt <= '0;
    end else if (w_byte_done) begin
      r_gap_cnt <= c_gap_load;
    end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
      r_gap_cnt <= r_gap_cnt - c_gap_w'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module   : tb_uart_tx_sched
// Purpose  : Self-checking bench for uart_tx_sched with a transaction-level
//            reference model and a reactive UART core model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_sched;

  localparam int CW = 4;
  localparam int GAP_PARAM = 348;
`ifdef UART_TX_SCHED_GAP_EN
  localparam int GAP = GAP_PARAM;
`else
  localparam int GAP = 0;
`endif

  typedef struct packed {
    logic       last;
    logic [7:0] d;
  } item_t;

  logic          clock = 1'b0;
  logic          resetb = 1'b0;
  logic [1:0]    in_valid = 2'b00;
  logic [15:0]   in_data = 16'h0000;
  logic [1:0]    in_last = 2'b00;
  logic [1:0]    in_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;
  logic          owner;
  logic          locked;
  logic [CW-1:0] sent_cnt;
  logic          idle;

  always #5 clock = ~clock;

  uart_tx_sched #(.CNT_W(CW), .GAP_CYCLES(GAP_PARAM)) dut (
    .clock(clock), .resetb(resetb), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .owner(owner), .locked(locked),
    .sent_cnt(sent_cnt), .idle(idle)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit         m_owner = 1'b1;
  bit         m_locked = 1'b0;
  bit         m_pending = 1'b0;  // start requested, core not yet busy
  bit         m_inbusy = 1'b0;   // core transmitting our byte
  logic [7:0] m_data = 8'h00;
  int         m_cnt = 0;
  int         m_gap = 0;         // idle cycles still owed after a byte
  logic [8:0] glog[$];           // {channel, byte} in grant order
  int         w_pick;
  bit         w_free;
  logic [1:0] exp_ready;

  function automatic int pick(input logic [1:0] v, input bit own, input bit lk);
    if (lk) return (v[own] == 1'b1) ? int'(own) : -1;
    if (v == 2'b11) return own ? 0 : 1;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  always_comb begin
    w_pick    = pick(in_valid, m_owner, m_locked);
    w_free    = !m_pending && !m_inbusy && (m_gap == 0);
    exp_ready = 2'b00;
    if (w_free && !tx_busy && (w_pick >= 0)) exp_ready = (w_pick == 1) ? 2'b10 : 2'b01;
  end

  always @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      m_owner <= 1'b1; m_locked <= 1'b0; m_pending <= 1'b0; m_inbusy <= 1'b0;
      m_data <= 8'h00; m_cnt <= 0; m_gap <= 0;
    end else if (w_free) begin
      if (!tx_busy && (w_pick >= 0)) begin
        m_owner   <= w_pick[0];
        m_locked  <= !((w_pick == 1) ? in_last[1] : in_last[0]);
        m_data    <= (w_pick == 1) ? in_data[15:8] : in_data[7:0];
        m_pending <= 1'b1;
        glog.push_back({w_pick[0], ((w_pick == 1) ? in_data[15:8] : in_data[7:0])});
      end
    end else if (m_pending) begin
      if (tx_busy) begin m_pending <= 1'b0; m_inbusy <= 1'b1; end
    end else if (m_inbusy) begin
      if (!tx_busy) begin
        m_inbusy <= 1'b0;
        m_cnt    <= (m_cnt + 1) % (1 << CW);
        m_gap    <= GAP;
      end
    end else begin
      m_gap <= m_gap - 1;
    end
  end

  // ---------------- per-cycle compare + stimulus sampling ----------------
  logic [1:0] acc = 2'b00;
  logic       start_seen = 1'b0;

  always @(negedge clock) begin
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("tx_start", 32'(tx_start), 32'(m_pending));
    chk("tx_data",  32'(tx_data),  32'(m_data));
    chk("owner",    32'(owner),    32'(m_owner));
    chk("locked",   32'(locked),   32'(m_locked));
    chk("sent_cnt", 32'(sent_cnt), 32'(m_cnt));
    chk("idle",     32'(idle),     32'(w_free));
    acc        <= in_valid & in_ready;
    start_seen <= tx_start;
  end

  // ---------------- producers and UART core model ----------------
  item_t q0[$], q1[$];
  logic [1:0] pres = 2'b00;
  bit  rand_gate = 1'b0, core_rand = 1'b0, force_busy = 1'b0, c_active = 1'b0;
  int  core_delay = 2, core_hold = 100, c_wait = 0, c_hold = 0;
  int  cyc = 0, fall_cnt = 0, fall_cyc = 0;

  initial forever begin @(posedge clock); cyc++; end

  task automatic drive_step();
    logic prev_busy;
    prev_busy = tx_busy;
    if (!resetb) begin
      pres = 2'b00; in_valid = 2'b00; c_active = 1'b0; tx_busy = 1'b0;
      return;
    end
    if (acc[0] && q0.size() > 0) begin q0.delete(0); pres[0] = 1'b0; end
    if (acc[1] && q1.size() > 0) begin q1.delete(0); pres[1] = 1'b0; end
    if (!pres[0] && q0.size() > 0 && (!rand_gate || $urandom_range(0, 1) == 1)) pres[0] = 1'b1;
    if (!pres[1] && q1.size() > 0 && (!rand_gate || $urandom_range(0, 1) == 1)) pres[1] = 1'b1;
    in_valid = pres;
    in_data  = 16'($urandom);
    in_last  = 2'($urandom);
    if (pres[0]) begin in_data[7:0]  = q0[0].d; in_last[0] = q0[0].last; end
    if (pres[1]) begin in_data[15:8] = q1[0].d; in_last[1] = q1[0].last; end
    if (force_busy) begin
      tx_busy = 1'b1;
    end else begin
      if (!c_active && start_seen) begin
        c_active = 1'b1;
        c_wait   = core_rand ? $urandom_range(0, 3) : core_delay;
        c_hold   = core_rand ? $urandom_range(1, 8) : core_hold;
      end
      if (!c_active)            tx_busy = 1'b0;
      else if (c_wait > 0)      begin c_wait--; tx_busy = 1'b0; end
      else if (c_hold > 0)      begin c_hold--; tx_busy = 1'b1; end
      else                      begin tx_busy = 1'b0; c_active = 1'b0; end
    end
    if (prev_busy && !tx_busy) begin fall_cnt++; fall_cyc = cyc; end
  endtask

  initial forever begin @(posedge clock); #1; drive_step(); end

  task automatic push(input int c, input logic last, input logic [7:0] d);
    item_t it;
    it.last = last; it.d = d;
    if (c == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end
    while (!(q0.size() == 0 && q1.size() == 0 && in_valid == 2'b00 && idle === 1'b1
             && !c_active) && n < budget);
    chk({name, "_drain"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while ((in_valid & in_ready) == 2'b00 && n < 200);
    chk({name, "_accept"}, 32'(n < 200), 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clock); resetb = 1'b0;
    q0.delete(); q1.delete();
    repeat (2) @(negedge clock);
    resetb = 1'b1;
  endtask

  task automatic check_log(input string name, input logic [8:0] exp[], input int n);
    chk({name, "_len"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", name, i), 32'(glog[i]), 32'(exp[i]));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    logic [8:0] exp_rr[] = '{9'h010, 9'h120, 9'h011, 9'h121, 9'h012, 9'h122, 9'h013, 9'h123};
    logic [8:0] exp_lk[] = '{9'h1A0, 9'h1A1, 9'h1A2, 9'h030, 9'h031};
    logic [8:0] exp_rs[] = '{9'h0C0, 9'h1C1};
    logic [8:0] e0[$], e1[$];
    int n, fb, t0, i0, i1;

    // Reset values.
    repeat (3) @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);
    chk("rst_owner",    32'(owner),    32'd1);
    chk("rst_locked",   32'(locked),   32'd0);
    chk("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    chk("rst_idle",     32'(idle),     32'd1);
    resetb = 1'b1;

    // Single byte, core busy 2 cycles after start for 100 cycles.
    push(0, 1'b1, 8'h01);
    wait_accept("single");
    @(negedge clock);
    chk("single_tx_start", 32'(tx_start), 32'd1);
    chk("single_tx_data",  32'(tx_data),  32'h01);
    chk("single_owner",    32'(owner),    32'd0);
    wait_drained("single", 400 + GAP);
    chk("single_sent_cnt", 32'(sent_cnt), 32'd1);
    chk("single_locked",   32'(locked),   32'd0);

    // Round-robin from a fresh reset: ch0 first, then alternate.
    core_delay = 1; core_hold = 5;
    apply_reset();
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 8'(8'h10 + i));
      push(1, 1'b1, 8'(8'h20 + i));
    end
    wait_drained("rr", 400 + 8 * GAP);
    check_log("rr", exp_rr, 8);
    chk("rr_sent_cnt", 32'(sent_cnt), 32'd8);

    // Frame lock: ch1 frame of three bytes wins over a waiting ch0.
    push(0, 1'b1, 8'h2F);
    wait_drained("lk_pre", 200 + GAP);
    glog.delete();
    push(1, 1'b0, 8'hA0); push(1, 1'b0, 8'hA1); push(1, 1'b1, 8'hA2);
    push(0, 1'b1, 8'h30); push(0, 1'b1, 8'h31);
    wait_accept("lk");
    @(negedge clock);
    chk("lk_locked", 32'(locked), 32'd1);
    chk("lk_owner",  32'(owner),  32'd1);
    wait_drained("lk", 400 + 5 * GAP);
    check_log("lk", exp_lk, 5);
    chk("lk_unlocked", 32'(locked), 32'd0);

    // Busy-held core: no grant until tx_busy falls, then grant at once.
    force_busy = 1'b1;
    repeat (2) @(negedge clock);
    push(0, 1'b1, 8'h40);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (in_ready != 2'b00) n++;
    end
    chk("busyheld_no_ready", 32'(n), 32'd0);
    force_busy = 1'b0;
    @(negedge clock);
    chk("busyheld_grant", 32'(in_ready), 32'b01);
    wait_drained("busyheld", 200 + GAP);

    // Reset mid-frame while the core is busy and the frame is locked.
    push(1, 1'b0, 8'hB0);
    n = 0;
    do begin @(negedge clock); n++; end while (!(m_inbusy && m_locked) && n < 200);
    chk("midrst_reach", 32'(n < 200), 32'd1);
    #2 resetb = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_tx_data",  32'(tx_data),  32'h00);
    chk("midrst_owner",    32'(owner),    32'd1);
    chk("midrst_locked",   32'(locked),   32'd0);
    chk("midrst_sent_cnt", 32'(sent_cnt), 32'd0);
    chk("midrst_idle",     32'(idle),     32'd1);
    q0.delete(); q1.delete(); glog.delete();
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    push(0, 1'b1, 8'hC0); push(1, 1'b1, 8'hC1);
    wait_drained("midrst", 200 + 2 * GAP);
    check_log("midrst", exp_rs, 2);

    // Busy fall to next in_ready: GAP+1 cycles.
    core_hold = 10;
    fb = fall_cnt;
    push(0, 1'b1, 8'hD0); push(0, 1'b1, 8'hD1);
    n = 0;
    do begin @(negedge clock); n++; end while (fall_cnt == fb && n < 200);
    t0 = fall_cyc;
    n = 0;
    do begin @(negedge clock); n++; end while (in_ready == 2'b00 && n < GAP + 50);
    chk("gap_latency", 32'(cyc - t0), 32'(GAP + 1));
    wait_drained("gap", 200 + 2 * GAP);

    // Randomized traffic; 65 bytes since the last reset wraps sent_cnt to 1.
    core_rand = 1'b1; rand_gate = 1'b1;
    glog.delete();
    for (int i = 0; i < 30; i++) begin
      e0.push_back({1'b0, 8'($urandom)});
      push(0, (i == 29) ? 1'b1 : 1'($urandom_range(0, 2) != 0), e0[i][7:0]);
    end
    for (int i = 0; i < 31; i++) begin
      e1.push_back({1'b1, 8'($urandom)});
      push(1, (i == 30) ? 1'b1 : 1'($urandom_range(0, 2) != 0), e1[i][7:0]);
    end
    wait_drained("rand", 3000 + 61 * (GAP + 40));
    chk("rand_len", 32'(glog.size()), 32'd61);
    chk("rand_sent_cnt", 32'(sent_cnt), 32'd1);
    i0 = 0; i1 = 0;
    foreach (glog[k]) begin
      if (glog[k][8] == 1'b0) begin
        chk("rand_ch0_order", 32'(glog[k]), 32'(e0[i0])); i0++;
      end else begin
        chk("rand_ch1_order", 32'(glog[k]), 32'(e1[i1])); i1++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Byte scheduler that shares one UART transmitter between two byte-stream requesters (channel 0, channel 1) in the Caravel user project. It arbitrates round-robin, locks the transmitter to one channel for the length of a frame (`last`-terminated), and drives the transmitter's `tx_start` / `tx_data` / `tx_busy` handshake. It sits between on-chip producers (firmware mailbox, LA-driven test source) and the UART TX core whose serial output is routed to `mprj_io[6]`.

## Interface

Parameters:
- `CNT_W`, default 16: width of the sent-byte counter.
- `GAP_CYCLES`, default 348: idle cycles inserted after each byte when the gap feature is compiled in. 348 cycles is 8.7 µs at a 25 ns clock.

Ports (name, direction, width, meaning):
- `clock`, in, 1: single clock for the block.
- `resetb`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 2: per-channel byte valid.
- `in_data`, in, 16: channel 0 byte on bits [7:0], channel 1 byte on bits [15:8].
- `in_last`, in, 2: per-channel end-of-frame flag, qualified by `in_valid`.
- `in_ready`, out, 2: per-channel accept, one-hot or zero.
- `tx_start`, out, 1: start request to the UART TX core.
- `tx_data`, out, 8: byte to transmit. Held stable while `tx_start` is high.
- `tx_busy`, in, 1: UART TX core busy.
- `owner`, out, 1: channel of the byte currently or most recently accepted.
- `locked`, out, 1: a frame is open; only `owner` may be granted.
- `sent_cnt`, out, `CNT_W`: completed bytes; wraps modulo 2^`CNT_W`.
- `idle`, out, 1: high when the state is IDLE.

## Operation

State machine: IDLE → START → BUSY → (GAP) → IDLE.

- **IDLE**
  - A grant is possible only when `tx_busy` is 0.
  - Eligible channels: if `locked`, only `owner`; otherwise any channel with `in_valid` set.
  - When both channels are eligible, round-robin picks the channel that is not `owner`.
  - `in_ready` is combinational and high for the granted channel only.
  - On an edge where `in_valid & in_ready`:
    - capture the byte into `tx_data`;
    - set `owner`;
    - set `locked` to the inverse of `in_last` for that channel;
    - go to START.
- **START**
  - `tx_start` is 1 and `tx_data` is held.
  - When `tx_busy` is sampled 1, go to BUSY; `tx_start` is 0 from that next cycle.
- **BUSY**
  - When `tx_busy` is sampled 0:
    - `sent_cnt` increments by 1;
    - go to GAP if the gap feature is compiled in and `GAP_CYCLES` > 0; otherwise go to IDLE.
- **GAP**
  - A down-counter is loaded with `GAP_CYCLES` - 1 on entry.
  - When the counter is 0, go to IDLE.
- A locked frame holds the transmitter indefinitely, even if the other channel is valid. Unlocking requires a byte with `last` set.
- `in_ready` is 0 in every state except IDLE.

## Timing

- Reset values: `in_ready` = 0, `tx_start` = 0, `tx_data` = 0x00, `owner` = 1 (so channel 0 wins first), `locked` = 0, `sent_cnt` = 0, `idle` = 1. The gap counter resets to 0 and the state to IDLE.
- Latency:
  - Accept edge → `tx_start` = 1 on the next cycle.
  - `tx_busy` fall → `idle` = 1 on the next cycle without the gap feature, or `GAP_CYCLES` + 1 cycles later with it.
- Minimum byte spacing: 4 cycles plus the core's busy time, excluding the gap. Back-to-back transfers are not required.
- If `tx_busy` is already high in IDLE (an external user of the core), no grant is made until it falls.
- If `tx_busy` never rises after `tx_start`, the block stays in START. There is no timeout.
- A `resetb` assertion mid-byte or mid-frame takes effect immediately and asynchronously: all outputs return to their reset values and the lock is dropped.
- `sent_cnt` wraps from 2^`CNT_W`-1 to 0 with no flag.

## Configuration

- `UART_TX_SCHED_GAP_EN` defined:
  - the GAP state and its counter (width `$clog2(GAP_CYCLES+1)`) are built;
  - each byte is followed by `GAP_CYCLES` idle cycles before the next grant.
- Not defined:
  - no GAP state and no counter;
  - BUSY exits directly to IDLE;
  - `GAP_CYCLES` is ignored.

## Test plan

- **Reset and single byte:** release reset; ch0 sends 0x01 with `last` = 1; core model raises `tx_busy` 2 cycles after `tx_start` and holds it 100 cycles.
  - Expect `tx_start` high the cycle after accept, `tx_data` = 0x01, `sent_cnt` = 1, `locked` = 0.
- **Round-robin:** both channels continuously valid, all bytes `last` = 1, ch0 = 0x10.., ch1 = 0x20...
  - Expect grant order ch0, ch1, ch0, ch1; `tx_data` = 0x10, 0x20, 0x11, 0x21.
- **Frame lock:** ch1 sends 3 bytes 0xA0, 0xA1, 0xA2 with `last` only on 0xA2, while ch0 is valid throughout.
  - Expect all three ch1 bytes before any ch0 byte; `locked` is 1 from the first accept until the 0xA2 accept.
- **Busy-held core:** `tx_busy` forced high in IDLE for 50 cycles with ch0 valid.
  - Expect `in_ready` = 0 throughout; grant on the first cycle after `tx_busy` falls.
- **Reset mid-frame:** pulse `resetb` low while in BUSY with `locked` = 1.
  - Expect all outputs at reset values immediately; the next grant goes to ch0.
- **Gap feature:** with `UART_TX_SCHED_GAP_EN` defined and `GAP_CYCLES` = 348, measure from the `tx_busy` fall to the next `in_ready`.
  - Expect 349 cycles with the macro defined, and 1 cycle without it.
